// File: rtl/ui_digit_editor.sv
// Front-panel editor: synchronised/debounced buttons drive a 5-bit cursor over a
// 32-bit digit image, plus a prescaled free-running slow_clock time base.

module ui_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic press
);
    logic        sync1, sync2, state;
    logic [15:0] cnt;
    logic        flip;

    // Flip on the DEBOUNCE_CYCLES-th consecutive differing sample.
    assign flip  = (sync2 != state) && (cnt == 16'(DEBOUNCE_CYCLES - 1));
    assign press = flip && !state;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == state) begin
                cnt <= '0;
            end else if (flip) begin
                state <= ~state;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

module ui_digit_editor #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PRESCALE        = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        prog_running,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_toggle,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic [4:0]  digit,
    output logic [31:0] digits,
    output logic [31:0] slow_clock,
    output logic        edit_strobe
);
    localparam int PW = $clog2(PRESCALE);

    logic [2:0]    press;
    logic          ev_left, ev_right, ev_toggle;
    logic [PW-1:0] prescaler;

    // One debouncer per button: [0]=left, [1]=right, [2]=toggle.
    ui_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [2:0] (
        .clock  (clock),
        .reset_n(reset_n),
        .raw    ({btn_toggle, btn_right, btn_left}),
        .press  (press)
    );

    // Debouncing keeps running while locked out; only the events are dropped.
    assign ev_left   = press[0] && !prog_running;
    assign ev_right  = press[1] && !prog_running;
    assign ev_toggle = press[2] && !prog_running;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            digit       <= '0;
            digits      <= '0;
            edit_strobe <= 1'b0;
        end else begin
            if (ev_left && !ev_right)
                digit <= digit + 5'd1;
            else if (ev_right && !ev_left)
                digit <= digit - 5'd1;

            // Toggle uses the pre-move cursor; a load on the same edge wins.
            if (load_valid)
                digits <= load_data;
            else if (ev_toggle)
                digits[digit] <= ~digits[digit];

            edit_strobe <= ev_toggle && !load_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prescaler  <= '0;
            slow_clock <= '0;
        end else if (prescaler == PW'(PRESCALE - 1)) begin
            prescaler  <= '0;
            slow_clock <= slow_clock + 32'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end
endmodule

// File: tb/tb_ui_digit_editor.sv
// Directed bench for ui_digit_editor with DEBOUNCE_CYCLES=4, PRESCALE=8.

module tb_ui_digit_editor;
    logic        clock = 1'b0;
    logic        reset_n, prog_running, btn_left, btn_right, btn_toggle, load_valid;
    logic [31:0] load_data;
    logic [4:0]  digit;
    logic [31:0] digits, slow_clock;
    logic        edit_strobe;

    int tests = 0;
    int failed = 0;
    int strobes = 0;
    int bad = 0;

    ui_digit_editor #(.DEBOUNCE_CYCLES(4), .PRESCALE(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .prog_running(prog_running),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_toggle  (btn_toggle),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .digit       (digit),
        .digits      (digits),
        .slow_clock  (slow_clock),
        .edit_strobe (edit_strobe)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mask: [0]=left [1]=right [2]=toggle; edit_strobe pulses are accumulated.
    task automatic press(input logic [2:0] mask);
        btn_left   = mask[0];
        btn_right  = mask[1];
        btn_toggle = mask[2];
        repeat (8) begin
            tick(1);
            strobes += int'(edit_strobe);
        end
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        btn_toggle = 1'b0;
        repeat (8) begin
            tick(1);
            strobes += int'(edit_strobe);
        end
    endtask

    initial begin
        reset_n = 1'b0; prog_running = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_toggle = 1'b0; load_valid = 1'b0; load_data = '0;
        tick(2);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_digits", digits, 32'd0);
        check("rst_slow", slow_clock, 32'd0);
        check("rst_strobe", 32'(edit_strobe), 32'd0);
        reset_n = 1'b1;

        // Latency: raw captured at edge 1, cursor moves at edge 1+1+4 = 6.
        btn_left = 1'b1;
        tick(5);
        check("latency_early", 32'(digit), 32'd0);
        tick(1);
        check("latency_hit", 32'(digit), 32'd1);
        repeat (100) begin
            tick(1);
            if (digit !== 5'd1) bad++;
        end
        check("hold_no_repeat", 32'(bad), 32'd0);
        btn_left = 1'b0;
        tick(10);

        btn_left = 1'b1;
        tick(3);
        btn_left = 1'b0;
        tick(10);
        check("glitch", 32'(digit), 32'd1);

        repeat (30) press(3'b001);
        check("left_to_31", 32'(digit), 32'd31);
        press(3'b001);
        check("wrap_31_0", 32'(digit), 32'd0);
        press(3'b010);
        check("wrap_0_31", 32'(digit), 32'd31);

        repeat (6) press(3'b001);
        check("at_5", 32'(digit), 32'd5);
        strobes = 0;
        press(3'b100);
        check("toggle_set", digits, 32'h0000_0020);
        check("toggle_strobe1", 32'(strobes), 32'd1);
        press(3'b100);
        check("toggle_clr", digits, 32'h0);
        check("toggle_strobe2", 32'(strobes), 32'd2);

        press(3'b011);
        check("lr_cancel", 32'(digit), 32'd5);
        press(3'b010);
        press(3'b010);
        check("at_3", 32'(digit), 32'd3);
        press(3'b101);
        check("tog_left_bits", digits, 32'h0000_0008);
        check("tog_left_digit", 32'(digit), 32'd4);

        // Load lands on the same edge as the debounced toggle (edge 6).
        btn_toggle = 1'b1;
        tick(5);
        load_valid = 1'b1;
        load_data  = 32'hA5A5_A5A5;
        tick(1);
        check("load_beats_tog", digits, 32'hA5A5_A5A5);
        check("load_no_strobe", 32'(edit_strobe), 32'd0);
        load_valid = 1'b0;
        btn_toggle = 1'b0;
        tick(10);
        check("load_kept", digits, 32'hA5A5_A5A5);
        check("load_digit", 32'(digit), 32'd4);

        prog_running = 1'b1;
        strobes = 0;
        press(3'b001);
        press(3'b010);
        press(3'b100);
        check("lock_digit", 32'(digit), 32'd4);
        check("lock_digits", digits, 32'hA5A5_A5A5);
        check("lock_strobe", 32'(strobes), 32'd0);
        load_valid = 1'b1;
        load_data  = 32'h1234_5678;
        tick(1);
        load_valid = 1'b0;
        check("lock_load", digits, 32'h1234_5678);

        btn_toggle = 1'b1;
        tick(10);
        prog_running = 1'b0;
        repeat (10) begin
            tick(1);
            strobes += int'(edit_strobe);
        end
        btn_toggle = 1'b0;
        tick(10);
        check("held_thru_stop", digits, 32'h1234_5678);
        check("held_no_strobe", 32'(strobes), 32'd0);
        check("slow_running", 32'(slow_clock != 32'd0), 32'd1);

        // Reset in the middle of a debounce and a prescale count.
        btn_left = 1'b1;
        tick(4);
        reset_n  = 1'b0;
        btn_left = 1'b0;
        tick(1);
        check("mid_rst_digit", 32'(digit), 32'd0);
        check("mid_rst_digits", digits, 32'd0);
        check("mid_rst_slow", slow_clock, 32'd0);
        check("mid_rst_strobe", 32'(edit_strobe), 32'd0);
        reset_n = 1'b1;
        tick(7);
        check("pre_7", slow_clock, 32'd0);
        tick(1);
        check("pre_8", slow_clock, 32'd1);
        tick(8);
        check("pre_16", slow_clock, 32'd2);
        check("no_event_after_rst", 32'(digit), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
